// File: rtl/gecko_data_memory_responder_if.sv
// Request/response bus between the gecko load/store formatter and the data memory responder.
//   req_*  : word-aligned request (address, byte write mask, lane-aligned store value, read flag,
//            tag), handshaked by req_valid/req_ready.
//   resp_* : raw 32-bit read word plus echoed tag, handshaked by resp_valid/resp_ready.
// master = core side, slave = memory responder side.
interface gecko_data_memory_responder_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned ID_WIDTH   = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_read_enable;
  logic [3:0]            req_write_mask;
  logic [31:0]           req_value;
  logic [ID_WIDTH-1:0]   req_id;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_value;
  logic [ID_WIDTH-1:0]   resp_id;

  modport master (
    output req_valid, req_addr, req_read_enable, req_write_mask, req_value, req_id, resp_ready,
    input  req_ready, resp_valid, resp_value, resp_id
  );

  modport slave (
    input  req_valid, req_addr, req_read_enable, req_write_mask, req_value, req_id, resp_ready,
    output req_ready, resp_valid, resp_value, resp_id
  );
endinterface

// File: rtl/gecko_data_memory_responder.sv
// Data memory responder for the gecko load/store path.
// Byte-masked writes into a local synchronous RAM; reads return the raw 32-bit word through a
// small response FIFO. Sign/zero extension of loads is done by the core.
// Ports:
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset (FIFO and inflight cleared, RAM kept)
//   bus   : slave side of gecko_data_memory_responder_if (request and response channels)
module gecko_data_memory_responder #(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned ID_WIDTH     = 4,
  parameter int unsigned BUFFER_DEPTH = 3
) (
  input logic                           clk,
  input logic                           rst_n,
  gecko_data_memory_responder_if.slave  bus
);
  localparam int unsigned Words = 2 ** ADDR_WIDTH;
  localparam int unsigned CntW  = $clog2(BUFFER_DEPTH + 1);
  localparam int unsigned PtrW  = $clog2(BUFFER_DEPTH);
  localparam logic [CntW-1:0] CntMax  = CntW'(BUFFER_DEPTH);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(BUFFER_DEPTH - 1);

  logic [31:0]         mem [Words];
  logic [31:0]         rd_data_q;
  logic [ID_WIDTH-1:0] rd_id_q;
  logic                inflight_q, inflight_d;

  logic [31:0]         fifo_value_q [BUFFER_DEPTH];
  logic [ID_WIDTH-1:0] fifo_id_q    [BUFFER_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;

  logic                accept, push, pop;
  logic [3:0]          lane_we;
  logic [CntW:0]       credits_used;

  // A read in flight already owns a FIFO slot, so it counts against the credit budget.
  // Only registered state feeds req_ready.
  always_comb begin
    credits_used   = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q};
    bus.req_ready  = credits_used < {1'b0, CntMax};
    bus.resp_valid = count_q != '0;
    bus.resp_value = fifo_value_q[rd_ptr_q];
    bus.resp_id    = fifo_id_q[rd_ptr_q];
  end

  always_comb begin
    accept     = bus.req_valid && bus.req_ready;
    lane_we    = accept ? bus.req_write_mask : 4'b0000;
    push       = inflight_q;
    pop        = bus.resp_valid && bus.resp_ready;
    inflight_d = accept && bus.req_read_enable;

    wr_ptr_d = wr_ptr_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
    end
    rd_ptr_d = rd_ptr_q;
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
    end

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // RAM: non-blocking read of the old word gives read-first behaviour when the same request
  // also writes.
  always_ff @(posedge clk) begin
    if (lane_we[0]) mem[bus.req_addr][7:0]   <= bus.req_value[7:0];
    if (lane_we[1]) mem[bus.req_addr][15:8]  <= bus.req_value[15:8];
    if (lane_we[2]) mem[bus.req_addr][23:16] <= bus.req_value[23:16];
    if (lane_we[3]) mem[bus.req_addr][31:24] <= bus.req_value[31:24];
    if (inflight_d) begin
      rd_data_q <= mem[bus.req_addr];
      rd_id_q   <= bus.req_id;
    end
  end

  // FIFO storage carries no reset; entries are only observed while count_q covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_value_q[wr_ptr_q] <= rd_data_q;
      fifo_id_q[wr_ptr_q]    <= rd_id_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  count_le_depth: assert property (@(posedge clk) disable iff (!rst_n) count_q <= CntMax);

endmodule

// File: tb/tb_gecko_data_memory_responder.sv
module tb_gecko_data_memory_responder;
  localparam int unsigned AW = 10;
  localparam int unsigned IW = 4;
  localparam int unsigned BD = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gecko_data_memory_responder_if #(.ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

  gecko_data_memory_responder #(
    .ADDR_WIDTH  (AW),
    .ID_WIDTH    (IW),
    .BUFFER_DEPTH(BD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [31:0]   value;
    logic [IW-1:0] id;
  } resp_t;

  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  resp_t exp_q[$];
  int    pop_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pre(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // Scoreboard monitor: compares every response handshake against the head of exp_q.
  always @(negedge clk) begin : mon
    resp_t e;
    if (rst_n && bus.resp_valid && bus.resp_ready) begin
      pop_cyc.push_back(cyc);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_resp: got value %0h id %0h want none", bus.resp_value,
                 bus.resp_id);
      end else begin
        e = exp_q.pop_front();
        if (bus.resp_value !== e.value || bus.resp_id !== e.id) begin
          bad++;
          $display("FAIL resp: got value %0h id %0h want value %0h id %0h", bus.resp_value,
                   bus.resp_id, e.value, e.id);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [AW-1:0] a, input logic re, input logic [3:0] m,
                      input logic [31:0] v, input logic [IW-1:0] id, input logic [31:0] exp_v,
                      output int acc_cyc, output int stalls);
    int n = 0;
    bus.req_valid       = 1'b1;
    bus.req_addr        = a;
    bus.req_read_enable = re;
    bus.req_write_mask  = m;
    bus.req_value       = v;
    bus.req_id          = id;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!bus.req_ready) begin
      total++;
      bad++;
      $display("FAIL req_accept: got timeout want accept for addr %0h", a);
    end else begin
      @(posedge clk);
      #1;
      if (re) exp_q.push_back({exp_v, id});
    end
    acc_cyc = cyc;
    stalls  = n;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, st, first, stall_sum;
    bus.req_valid = 0; bus.req_addr = '0; bus.req_read_enable = 0; bus.req_write_mask = '0;
    bus.req_value = '0; bus.req_id = '0; bus.resp_ready = 0;
    #12;
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_req_ready", bus.req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Preload addrs 0..7 and addr 9.
    for (int i = 0; i < 8; i++) send(AW'(i), 1'b0, 4'hF, pre(i), '0, '0, acc, st);
    send(10'd9, 1'b0, 4'hF, 32'h1234_5678, '0, '0, acc, st);

    // Backpressure: three reads fill the credit budget.
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(AW'(i), 1'b1, 4'h0, '0, IW'(i), pre(i), acc, st);
    bus.req_valid = 1'b1; bus.req_addr = 10'd3; bus.req_read_enable = 1'b1;
    bus.req_write_mask = 4'h0; bus.req_id = 4'd3;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_req_ready", bus.req_ready, 0);
      check("bp_head_value", bus.resp_value, pre(0));
      check("bp_head_id", bus.resp_id, 0);
    end
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b1;
    for (int i = 3; i < 8; i++) send(AW'(i), 1'b1, 4'h0, '0, IW'(i), pre(i), acc, st);
    drain();

    // Throughput: back-to-back reads with resp_ready held high.
    @(posedge clk);
    #1;
    pop_cyc.delete();
    stall_sum = 0;
    first = 0;
    for (int i = 0; i < 8; i++) begin
      send(AW'(i), 1'b1, 4'h0, '0, IW'(i + 8), pre(i), acc, st);
      if (i == 0) first = acc;
      stall_sum += st;
    end
    drain();
    check("tp_stalls", stall_sum, 0);
    check("tp_resp_count", pop_cyc.size(), 8);
    for (int j = 0; j < 8 && j < pop_cyc.size(); j++) check("tp_resp_cycle", pop_cyc[j], first + 1 + j);

    // Write-then-read with latency check.
    send(10'd5, 1'b0, 4'hF, 32'hDEAD_BEEF, 4'd0, '0, acc, st);
    send(10'd5, 1'b1, 4'h0, '0, 4'd3, 32'hDEAD_BEEF, acc, st);
    check("lat_accept_cycle", bus.resp_valid, 0);
    @(posedge clk);
    #1;
    check("lat_next_cycle", bus.resp_valid, 1);
    drain();

    // Byte mask merge.
    send(10'd2, 1'b0, 4'hF, 32'h1122_3344, '0, '0, acc, st);
    send(10'd2, 1'b0, 4'b0010, 32'h0000_AA00, '0, '0, acc, st);
    send(10'd2, 1'b1, 4'h0, '0, 4'd4, 32'h1122_AA44, acc, st);
    drain();

    // Read-first on combined read+write.
    send(10'd7, 1'b0, 4'hF, 32'h0000_0001, '0, '0, acc, st);
    send(10'd7, 1'b1, 4'hF, 32'hCAFE_F00D, 4'd5, 32'h0000_0001, acc, st);
    send(10'd7, 1'b1, 4'h0, '0, 4'd6, 32'hCAFE_F00D, acc, st);
    drain();

    // Reset mid-operation with two responses buffered.
    bus.resp_ready = 1'b0;
    send(10'd0, 1'b1, 4'h0, '0, 4'd1, pre(0), acc, st);
    send(10'd1, 1'b1, 4'h0, '0, 4'd2, pre(1), acc, st);
    @(posedge clk);
    #1;
    check("pre_rst_resp_valid", bus.resp_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_resp_valid", bus.resp_valid, 0);
    check("mid_rst_req_ready", bus.req_ready, 1);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_resp_valid", bus.resp_valid, 0);
    bus.resp_ready = 1'b1;
    send(10'd9, 1'b1, 4'h0, '0, 4'd7, 32'h1234_5678, acc, st);
    drain();

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
